// File: rtl/lc3_exec_unit_if.sv
// Control/bus-side signal bundle for lc3_exec_unit: register/CC load strobes,
// operand selects, the MUL start/busy/done handshake and the ALU result.
interface lc3_exec_unit_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IMM_W    = 5
);
    localparam int RA_W = $clog2(NUM_REGS);

    logic              i_LD_REG;
    logic              i_LD_CC;
    logic [2:0]        i_ALUK;
    logic [1:0]        i_DRMUX;
    logic [1:0]        i_SR1MUX;
    logic [RA_W-1:0]   i_IR_DR;
    logic [RA_W-1:0]   i_IR_SR1;
    logic [RA_W-1:0]   i_IR_SR2;
    logic              i_IR_5;
    logic [IMM_W-1:0]  i_IMM;
    logic [DATA_W-1:0] i_bus;
    logic              i_start;
    logic              o_busy;
    logic              o_done;
    logic [2:0]        o_NZP;
    logic [DATA_W-1:0] o_ToBus;

    modport master (
        output i_LD_REG, i_LD_CC, i_ALUK, i_DRMUX, i_SR1MUX, i_IR_DR, i_IR_SR1,
               i_IR_SR2, i_IR_5, i_IMM, i_bus, i_start,
        input  o_busy, o_done, o_NZP, o_ToBus
    );

    modport slave (
        input  i_LD_REG, i_LD_CC, i_ALUK, i_DRMUX, i_SR1MUX, i_IR_DR, i_IR_SR1,
               i_IR_SR2, i_IR_5, i_IMM, i_bus, i_start,
        output o_busy, o_done, o_NZP, o_ToBus
    );
endinterface

// File: rtl/lc3_exec_unit.sv
// LC-3 style register file + ALU with an iterative shift-add multiplier and NZP codes.
// Define LC3_EXEC_BYPASS_EN to forward a same-cycle register write onto the read ports.
module lc3_exec_unit #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IMM_W    = 5
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    lc3_exec_unit_if.slave bus_if
);
    localparam int RA_W  = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic [RA_W-1:0]   dr_addr;
    logic [RA_W-1:0]   sr1_addr;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] sr2_val;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;

    state_t            state_reg, state_next;
    logic              mul_accept;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_sum;
    logic [DATA_W-1:0] prod_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        nzp_reg;

    always_comb begin
        dr_addr = bus_if.i_IR_DR;
        case (bus_if.i_DRMUX)
            2'b00:   dr_addr = bus_if.i_IR_DR;
            2'b01:   dr_addr = RA_W'(NUM_REGS - 2);
            2'b10:   dr_addr = RA_W'(NUM_REGS - 1);
            default: dr_addr = '0;
        endcase
        sr1_addr = bus_if.i_IR_DR;
        case (bus_if.i_SR1MUX)
            2'b00:   sr1_addr = bus_if.i_IR_DR;
            2'b01:   sr1_addr = bus_if.i_IR_SR1;
            2'b10:   sr1_addr = RA_W'(NUM_REGS - 2);
            default: sr1_addr = '0;
        endcase
    end

    // One enable-gated register per entry so the whole file clears on reset.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge i_CLK or negedge i_RST_N) begin
                if (!i_RST_N)
                    regs_reg[gi] <= '0;
                else if (bus_if.i_LD_REG && (dr_addr == RA_W'(gi)))
                    regs_reg[gi] <= bus_if.i_bus;
            end
        end
    endgenerate

`ifdef LC3_EXEC_BYPASS_EN
    assign sr1_val = (bus_if.i_LD_REG && (dr_addr == sr1_addr)) ? bus_if.i_bus : regs_reg[sr1_addr];
    assign sr2_val = (bus_if.i_LD_REG && (dr_addr == bus_if.i_IR_SR2)) ? bus_if.i_bus
                                                                       : regs_reg[bus_if.i_IR_SR2];
`else
    assign sr1_val = regs_reg[sr1_addr];
    assign sr2_val = regs_reg[bus_if.i_IR_SR2];
`endif

    assign imm_sext = {{(DATA_W - IMM_W){bus_if.i_IMM[IMM_W-1]}}, bus_if.i_IMM};
    assign op_b     = bus_if.i_IR_5 ? imm_sext : sr2_val;

    always_comb begin
        alu_result = '0;
        case (bus_if.i_ALUK)
            3'b000:  alu_result = sr1_val + op_b;
            3'b001:  alu_result = sr1_val & op_b;
            3'b010:  alu_result = ~sr1_val;
            3'b011:  alu_result = sr1_val;
            3'b100:  alu_result = prod_reg;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mul_accept = 1'b0;
        mul_busy   = 1'b0;
        mul_done   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus_if.i_start && (bus_if.i_ALUK == 3'b100)) begin
                    mul_accept = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                mul_busy = 1'b1;
                if (cnt_reg == CNT_W'(1))
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                mul_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Multiplicand shifts left while the multiplier shifts right, LSB first.
    assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            prod_reg   <= '0;
        end else if (mul_accept) begin
            mcand_reg  <= sr1_val;
            mplier_reg <= op_b;
            acc_reg    <= '0;
            cnt_reg    <= CNT_W'(DATA_W);
        end else if (state_reg == ST_RUN) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1))
                prod_reg <= acc_sum;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N)
            nzp_reg <= 3'b010;
        else if (bus_if.i_LD_CC) begin
            if (bus_if.i_bus[DATA_W-1])
                nzp_reg <= 3'b100;
            else if (bus_if.i_bus == '0)
                nzp_reg <= 3'b010;
            else
                nzp_reg <= 3'b001;
        end
    end

    assign bus_if.o_busy  = mul_busy;
    assign bus_if.o_done  = mul_done;
    assign bus_if.o_NZP   = nzp_reg;
    assign bus_if.o_ToBus = alu_result;
endmodule

// File: tb/tb_lc3_exec_unit.sv
// Scoreboard bench for lc3_exec_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_lc3_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string       name;
        int          field;   // 0 ToBus, 1 NZP, 2 busy, 3 done
        logic [15:0] exp;
    } exp_t;

    typedef struct {
        logic [15:0] prod;
        int          done_cyc;
    } mul_exp_t;

    exp_t     comb_q[$];
    mul_exp_t mul_q[$];

    lc3_exec_unit_if #(.DATA_W(16), .NUM_REGS(8), .IMM_W(5)) u_if ();

    lc3_exec_unit #(.DATA_W(16), .NUM_REGS(8), .IMM_W(5)) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus_if  (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: drains queued combinational expectations and scores every done pulse.
    initial begin
        exp_t        e;
        mul_exp_t    m;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                case (e.field)
                    0:       act = u_if.o_ToBus;
                    1:       act = {13'b0, u_if.o_NZP};
                    2:       act = {15'b0, u_if.o_busy};
                    default: act = {15'b0, u_if.o_done};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end else
                    $display("ok   %s: %h", e.name, act);
            end
            if (u_if.o_done) begin
                checks++;
                if (mul_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
                end else begin
                    m = mul_q.pop_front();
                    if (u_if.o_ToBus !== m.prod || cyc != m.done_cyc || u_if.o_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL mul_done: got prod %h cycle %0d busy %b expected prod %h cycle %0d busy 0",
                                 u_if.o_ToBus, cyc, u_if.o_busy, m.prod, m.done_cyc);
                    end else
                        $display("ok   mul_done: prod %h at cycle %0d", u_if.o_ToBus, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input int field, input logic [15:0] exp);
        exp_t e;
        e.name  = name;
        e.field = field;
        e.exp   = exp;
        comb_q.push_back(e);
    endtask

    task automatic write_reg(input logic [1:0] drmux, input logic [2:0] dr, input logic [15:0] val);
        u_if.i_LD_REG = 1'b1;
        u_if.i_DRMUX  = drmux;
        u_if.i_IR_DR  = dr;
        u_if.i_bus    = val;
        step();
        u_if.i_LD_REG = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [15:0] exp, input string name);
        u_if.i_ALUK   = 3'b011;
        u_if.i_SR1MUX = 2'b01;
        u_if.i_IR_SR1 = a;
        expect_now(name, 0, exp);
        step();
    endtask

    task automatic ld_cc(input logic [15:0] val, input logic [2:0] exp, input string name);
        u_if.i_LD_CC = 1'b1;
        u_if.i_bus   = val;
        step();
        u_if.i_LD_CC = 1'b0;
        expect_now(name, 1, {13'b0, exp});
        step();
    endtask

    initial begin
        mul_exp_t    m;
        int          n;
        logic [15:0] byp_exp;

        u_if.i_LD_REG = 0; u_if.i_LD_CC = 0; u_if.i_ALUK = 3'b000; u_if.i_DRMUX = 0;
        u_if.i_SR1MUX = 0; u_if.i_IR_DR = 0; u_if.i_IR_SR1 = 0; u_if.i_IR_SR2 = 0;
        u_if.i_IR_5 = 0; u_if.i_IMM = 0; u_if.i_bus = 0; u_if.i_start = 0;

        // Reset state
        step(); step();
        expect_now("rst_tobus", 0, 16'h0000);
        expect_now("rst_nzp",   1, 16'h0002);
        expect_now("rst_busy",  2, 16'h0000);
        expect_now("rst_done",  3, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++)
            read_reg(3'(i), 16'h0000, $sformatf("rst_r%0d", i));
        u_if.i_ALUK = 3'b100;
        expect_now("rst_prod", 0, 16'h0000);
        step();

        // ALU operations
        write_reg(2'b00, 3'd1, 16'h0005);
        write_reg(2'b00, 3'd2, 16'hFFFD);
        u_if.i_SR1MUX = 2'b01; u_if.i_IR_SR1 = 3'd1; u_if.i_IR_SR2 = 3'd2; u_if.i_IR_5 = 0;
        u_if.i_ALUK = 3'b000; expect_now("add_reg", 0, 16'h0002); step();
        u_if.i_IR_5 = 1; u_if.i_IMM = 5'b10000;
        expect_now("add_imm", 0, 16'hFFF5); step();
        u_if.i_IR_5 = 0;
        u_if.i_ALUK = 3'b001; expect_now("and_reg", 0, 16'h0005); step();
        u_if.i_ALUK = 3'b010; expect_now("not_a",   0, 16'hFFFA); step();
        u_if.i_ALUK = 3'b101; expect_now("undef_op", 0, 16'h0000); step();

        // MUL 7 x 6: one busy sample, an ignored restart and a mid-run write
        write_reg(2'b00, 3'd1, 16'h0007);
        write_reg(2'b00, 3'd2, 16'h0006);
        u_if.i_SR1MUX = 2'b01; u_if.i_IR_SR1 = 3'd1; u_if.i_IR_SR2 = 3'd2; u_if.i_IR_5 = 0;
        u_if.i_ALUK = 3'b100; u_if.i_start = 1;
        m.prod = 16'h002A; m.done_cyc = cyc + 17;
        mul_q.push_back(m);
        step();
        u_if.i_start = 0;
        expect_now("mul_busy", 2, 16'h0001);
        step();
        u_if.i_start = 1;
        step();
        u_if.i_start = 0;
        write_reg(2'b00, 3'd1, 16'h0003);
        n = 0;
        while (mul_q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (mul_q.size() != 0) begin
            errors++;
            $display("FAIL mul_timeout: got %0d pending products expected 0", mul_q.size());
            mul_q.delete();
        end
        step();
        expect_now("mul_hold", 0, 16'h002A);
        expect_now("mul_idle_busy", 2, 16'h0000);
        step();

        // Condition codes, including a simultaneous register load
        ld_cc(16'h8000, 3'b100, "nzp_neg");
        ld_cc(16'h0000, 3'b010, "nzp_zero");
        ld_cc(16'h0001, 3'b001, "nzp_pos");
        u_if.i_LD_CC = 1;
        write_reg(2'b00, 3'd4, 16'hC000);
        u_if.i_LD_CC = 0;
        expect_now("nzp_with_ld", 1, 16'h0004);
        read_reg(3'd4, 16'hC000, "r4_with_cc");

        // Reset in the middle of a MUL
        u_if.i_SR1MUX = 2'b01; u_if.i_IR_SR1 = 3'd1; u_if.i_IR_SR2 = 3'd2;
        u_if.i_ALUK = 3'b100; u_if.i_start = 1;
        step();
        u_if.i_start = 0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        expect_now("abort_busy",  2, 16'h0000);
        expect_now("abort_done",  3, 16'h0000);
        expect_now("abort_prod",  0, 16'h0000);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) step();
        expect_now("abort_prod_after", 0, 16'h0000);
        expect_now("abort_nzp", 1, 16'h0002);
        step();
        read_reg(3'd1, 16'h0000, "abort_r1");

        // Destination / source muxes
        write_reg(2'b10, 3'd0, 16'h1234);
        read_reg(3'd7, 16'h1234, "drmux10_r7");
        write_reg(2'b01, 3'd0, 16'h0BEE);
        read_reg(3'd6, 16'h0BEE, "drmux01_r6");
        write_reg(2'b11, 3'd5, 16'h00AA);
        read_reg(3'd0, 16'h00AA, "drmux11_r0");
        read_reg(3'd5, 16'h0000, "drmux11_r5_untouched");
        u_if.i_ALUK = 3'b011;
        u_if.i_SR1MUX = 2'b10; expect_now("sr1mux10", 0, 16'h0BEE); step();
        u_if.i_SR1MUX = 2'b11; expect_now("sr1mux11", 0, 16'h00AA); step();
        u_if.i_SR1MUX = 2'b00; u_if.i_IR_DR = 3'd7;
        expect_now("sr1mux00", 0, 16'h1234); step();

        // Write-to-read forwarding
        write_reg(2'b00, 3'd3, 16'h1111);
`ifdef LC3_EXEC_BYPASS_EN
        byp_exp = 16'hABCD;
`else
        byp_exp = 16'h1111;
`endif
        u_if.i_LD_REG = 1; u_if.i_DRMUX = 2'b00; u_if.i_IR_DR = 3'd3; u_if.i_bus = 16'hABCD;
        u_if.i_ALUK = 3'b011; u_if.i_SR1MUX = 2'b01; u_if.i_IR_SR1 = 3'd3;
        expect_now("bypass_passa", 0, byp_exp);
        step();
        u_if.i_LD_REG = 0;
        read_reg(3'd3, 16'hABCD, "r3_after_write");

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc3_exec_unit.md
Name: lc3_exec_unit

Overview:
- Parametrised successor to the LC-3 register-file/ALU datapath.
- Generalised in data width and register count.
- Adds a multi-cycle iterative multiplier with a start/busy/done handshake and an NZP condition-code register.
- Sits between the IR/control FSM and the shared bus; the top module gates o_ToBus onto the bus.

Parameters:
- DATA_W, 16, datapath and register width (>= 8).
- NUM_REGS, 8, register count, power of 2, >= 4; address width RA_W = clog2(NUM_REGS).
- IMM_W, 5, immediate field width, sign-extended to DATA_W.

Ports:
- i_CLK  in  1  clock, rising edge
- i_RST_N  in  1  asynchronous, active-low reset
- i_LD_REG  in  1  write i_bus into the selected DR on this edge
- i_LD_CC  in  1  update NZP from i_bus on this edge
- i_ALUK  in  3  operation: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 MUL, others yield 0
- i_DRMUX  in  2  DR select
- i_SR1MUX  in  2  SR1 select
- i_IR_DR  in  RA_W  IR destination field
- i_IR_SR1  in  RA_W  IR source-1 field
- i_IR_SR2  in  RA_W  IR source-2 field
- i_IR_5  in  1  1 = immediate operand B
- i_IMM  in  IMM_W  immediate field
- i_bus  in  DATA_W  bus value for register/CC load
- i_start  in  1  begin MUL (sampled in IDLE only)
- o_busy  out  1  MUL in progress
- o_done  out  1  one-cycle pulse when product is valid
- o_NZP  out  3  condition codes {N,Z,P}
- o_ToBus  out  DATA_W  ALU result

Behaviour:
- Reset (async, i_RST_N=0): all registers 0; NZP=3'b010; FSM=IDLE; o_busy=0; o_done=0; product register 0.
- Address muxes. DR: 00 i_IR_DR, 01 R(NUM_REGS-2), 10 R(NUM_REGS-1), 11 R0. SR1: 00 i_IR_DR, 01 i_IR_SR1, 10 R(NUM_REGS-2), 11 R0.
- Reads are combinational; writes occur on the rising edge when i_LD_REG=1.
- Operand B = i_IR_5 ? sign-extended i_IMM : SR2 read value.
- ADD/AND/NOT/PASSA are combinational, zero latency. ADD wraps modulo 2^DATA_W. NOT inverts A.
- MUL FSM:
  - IDLE: on i_start=1 with i_ALUK=100, latch A and B, clear the accumulator, load the bit counter with DATA_W, go to RUN, assert o_busy.
  - RUN: shift-add, one multiplier bit per cycle (LSB first). After DATA_W cycles, go to DONE.
  - DONE: lasts one cycle; o_done=1, o_busy=0; return to IDLE.
  - Result = low DATA_W bits of A*B (unsigned; identical to two's-complement low half).
  - Latency: start edge to done pulse = DATA_W+1 cycles.
- o_ToBus = product register when i_ALUK=100; otherwise the combinational result. The product holds until the next accepted start.
- i_start while busy or in DONE: ignored.
- Register writes during RUN are allowed and do not affect the latched operands.
- Reset mid-RUN aborts immediately: IDLE, product 0, no o_done pulse.
- NZP on i_LD_CC: N = i_bus[DATA_W-1]; Z = (i_bus==0); P = otherwise. Exactly one bit is set.
- Simultaneous i_LD_REG and i_LD_CC: both take effect on the same edge.

Optional Feature:
- Macro: LC3_EXEC_BYPASS_EN.
- Defined: when i_LD_REG=1 and the DR address equals the SR1 or SR2 address, that read port returns i_bus in the same cycle (write-to-read forwarding). The forwarded value also feeds the ALU, and the MUL operand latch on start.
- Undefined: reads return the pre-write register contents until the edge.

Test Plan:
- Reset then read all registers -> every read 0, o_NZP=010, o_busy=0, o_done=0, o_ToBus=0.
- Write R1=0x0005, R2=0xFFFD; ADD with SR1=R1, SR2=R2, i_IR_5=0 -> o_ToBus=0x0002. Same op with i_IR_5=1, i_IMM=5'b10000 -> o_ToBus=0xFFF5.
- MUL R1=0x0007 x R2=0x0006 with i_start pulse -> o_busy high 16 cycles; o_done pulses on cycle 17; o_ToBus=0x002A. A second i_start during busy is ignored.
- Deassert i_RST_N for 1 cycle mid-MUL (cycle 5) -> o_busy=0 asynchronously, no o_done, product=0.
- i_LD_CC with i_bus=0x8000 / 0x0000 / 0x0001 -> o_NZP=100 / 010 / 001. DRMUX=10 write 0x1234 -> R7=0x1234.
- LC3_EXEC_BYPASS_EN defined: i_LD_REG=1, DR=R3=SR1, i_bus=0xABCD, PASSA -> o_ToBus=0xABCD in the same cycle. Undefined -> old R3 value.
